// File: rtl/wb_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_buffer_if
//  Purpose  : Bundles the writeback capture stream, the show-ahead drain
//             port and the status counters of wb_trace_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  // Writeback capture side (driven by the core)
  logic               wb_en;
  logic [RD_W-1:0]    wb_rd;
  logic [DATA_W-1:0]  wb_data;

  // Drain side (show-ahead head entry)
  logic               out_valid;
  logic               out_ready;
  logic [RD_W-1:0]    out_rd;
  logic [DATA_W-1:0]  out_data;

  // Status
  logic [c_CNT_W-1:0] count;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic [31:0]        wb_total;

  // Core plus reader view: drives the writeback stream and the drain handshake
  modport master (
    output wb_en, wb_rd, wb_data, out_ready,
    input  out_valid, out_rd, out_data, count, overflow, drop_cnt, wb_total
  );

  // Trace buffer view
  modport slave (
    input  wb_en, wb_rd, wb_data, out_ready,
    output out_valid, out_rd, out_data, count, overflow, drop_cnt, wb_total
  );

endinterface
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_buffer
//  Purpose  : Captures every architectural register write leaving the
//             writeback stage into a show-ahead FIFO for in-order draining.
//             The core is never stalled: writes arriving while the FIFO is
//             full are dropped, flagged and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic clk,
  input  logic reset,   // asynchronous, active-low
  input  logic clear,   // synchronous, same effect as reset
  wb_trace_buffer_if.slave bus
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_ENTRY_W = RD_W + DATA_W;

  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [15:0]        c_DROP_MAX = 16'hFFFF;

  // Storage is never reset; the pointers and occupancy decide what is live.
  logic [c_ENTRY_W-1:0] r_mem [DEPTH];

  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic [15:0]          r_drop_cnt;
  logic [31:0]          r_wb_total;

  logic                 w_qualify;
  logic                 w_not_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_ENTRY_W-1:0] w_head;

  // Writes to x0 carry no architectural state and are filtered out entirely.
  assign w_qualify   = bus.wb_en && (bus.wb_rd != '0);
  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == c_FULL);
  assign w_pop       = w_not_empty && bus.out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push      = w_qualify && (!w_full || w_pop);
  assign w_drop      = w_qualify && !w_push;

  // Entry capture at the write pointer; clear discards the concurrent write.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= {bus.wb_rd, bus.wb_data};
    end
  end

  // Pointer and occupancy tracking for the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Trace statistics: total qualifying writes, drop counter and sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_wb_total <= '0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_wb_total <= '0;
    end else begin
      if (w_qualify) begin
        r_wb_total <= r_wb_total + 32'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != c_DROP_MAX) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  // Head entry is read purely from registered state; zeroed while empty.
  always_comb begin
    w_head = '0;
    if (w_not_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign bus.out_valid = w_not_empty;
  assign bus.out_rd    = w_head[c_ENTRY_W-1:DATA_W];
  assign bus.out_data  = w_head[DATA_W-1:0];
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.wb_total  = r_wb_total;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_trace_buffer
//  Purpose  : Self-checking bench for wb_trace_buffer: queue-based reference
//             model compared every cycle, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef logic [RD_W+DATA_W-1:0] entry_t;

  logic tb_clk = 1'b0;
  logic reset  = 1'b1;
  logic clear  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  wb_trace_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk   (tb_clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  entry_t      q[$];
  logic [15:0] m_drop  = '0;
  logic [31:0] m_total = '0;
  logic        m_over  = 1'b0;
  bit          m_qual, m_pop, m_was_full;

  // Model: a plain queue; pop before push so a full queue can take a write on a pop.
  always @(posedge tb_clk or negedge reset) begin
    if (!reset || (clear && reset)) begin
      q.delete();
      m_drop  = '0;
      m_total = '0;
      m_over  = 1'b0;
    end else begin
      m_qual     = bus.wb_en && (bus.wb_rd != 0);
      m_was_full = (q.size() == DEPTH);
      m_pop      = (q.size() != 0) && bus.out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_qual) begin
        m_total = m_total + 1;
        if (!m_was_full || m_pop) q.push_back({bus.wb_rd, bus.wb_data});
        else begin
          m_over = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
        end
      end
    end
  end

  entry_t m_head;

  // Compare every DUT output with the model away from the active edge.
  always @(negedge tb_clk) begin
    m_head = (q.size() != 0) ? q[0] : '0;
    check("m_valid",    64'(bus.out_valid), 64'(q.size() != 0));
    check("m_rd",       64'(bus.out_rd),    64'(m_head[RD_W+DATA_W-1:DATA_W]));
    check("m_data",     64'(bus.out_data),  64'(m_head[DATA_W-1:0]));
    check("m_count",    64'(bus.count),     64'(q.size()));
    check("m_overflow", 64'(bus.overflow),  64'(m_over));
    check("m_drop_cnt", 64'(bus.drop_cnt),  64'(m_drop));
    check("m_wb_total", 64'(bus.wb_total),  64'(m_total));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] data,
                       input logic rdy);
    bus.wb_en     = en;
    bus.wb_rd     = rd;
    bus.wb_data   = data;
    bus.out_ready = rdy;
  endtask

  int exp_next;
  logic [31:0] exp_drain;

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    #1 reset = 1'b0;
    step();
    step();
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_count", 64'(bus.count),     64'd0);
    check("reset_total", 64'(bus.wb_total),  64'd0);
    check("reset_data",  64'(bus.out_data),  64'd0);
    reset = 1'b1;

    // Single write visible one cycle after capture
    drive(1'b1, 5'd1, 32'h2, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_rd",    64'(bus.out_rd),    64'd1);
    check("single_data",  64'(bus.out_data),  64'h2);
    check("single_count", 64'(bus.count),     64'd1);
    check("single_total", 64'(bus.wb_total),  64'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("single_popped", 64'(bus.out_valid), 64'd0);

    // x0 filter after a clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("x0_valid", 64'(bus.out_valid), 64'd0);
    check("x0_count", 64'(bus.count),     64'd0);
    check("x0_total", 64'(bus.wb_total),  64'd0);

    // Fill past capacity
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, RD_W'(i), 32'h100 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("fill_count",    64'(bus.count),    64'd16);
    check("fill_overflow", 64'(bus.overflow), 64'd1);
    check("fill_drop",     64'(bus.drop_cnt), 64'd2);
    check("fill_total",    64'(bus.wb_total), 64'd18);
    check("fill_head",     64'(bus.out_data), 64'h101);

    // Full with simultaneous push and pop: no drop
    drive(1'b1, 5'd5, 32'hAA, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1);
    check("fullpp_count", 64'(bus.count),    64'd16);
    check("fullpp_drop",  64'(bus.drop_cnt), 64'd2);
    check("fullpp_head",  64'(bus.out_data), 64'h102);

    // Drain: 0x102..0x110 then 0xAA
    for (int i = 0; i < 16; i++) begin
      exp_drain = (i < 15) ? 32'h102 + 32'(i) : 32'hAA;
      check("drain_valid", 64'(bus.out_valid), 64'd1);
      check("drain_data",  64'(bus.out_data),  64'(exp_drain));
      step();
    end
    bus.out_ready = 1'b0;
    check("drain_empty", 64'(bus.out_valid), 64'd0);
    check("drain_count", 64'(bus.count),     64'd0);

    // Wrap-around: 40 push/pop pairs, ready toggling 1,0
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_next = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, RD_W'((i % 31) + 1), 32'(i), 1'b1);
      if (bus.out_valid) begin
        check("wrap_order", 64'(bus.out_data), 64'(exp_next));
        exp_next++;
      end
      step();
      drive(1'b0, '0, '0, 1'b0);
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid) begin
        check("wrap_order", 64'(bus.out_data), 64'(exp_next));
        exp_next++;
      end
      step();
    end
    bus.out_ready = 1'b0;
    check("wrap_all_read", 64'(exp_next),     64'd40);
    check("wrap_count",    64'(bus.count),    64'd0);
    check("wrap_overflow", 64'(bus.overflow), 64'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, RD_W'(i + 1), 32'h200 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("pre_reset_count", 64'(bus.count), 64'd7);
    #2 reset = 1'b0;
    #1;
    check("async_valid", 64'(bus.out_valid), 64'd0);
    check("async_count", 64'(bus.count),     64'd0);
    check("async_total", 64'(bus.wb_total),  64'd0);
    step();
    reset = 1'b1;

    // Clear overrides a concurrent push
    drive(1'b1, 5'd2, 32'h11, 1'b0);
    step();
    drive(1'b1, 5'd3, 32'h22, 1'b0);
    step();
    check("pre_clear_count", 64'(bus.count), 64'd2);
    drive(1'b1, 5'd3, 32'h55, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("clear_count", 64'(bus.count),     64'd0);
    check("clear_total", 64'(bus.wb_total),  64'd0);
    check("clear_valid", 64'(bus.out_valid), 64'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Sits directly downstream of the riscv core's writeback stage and consumes its register-file write stream (write enable, destination register, WB data).
- Stores each architectural register write in a FIFO so a bench or debug reader can drain and check the retirement trace in order, with valid/ready back-pressure.
- Never stalls the core: when the FIFO is full, new writes are dropped and counted.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, minimum 2.
- DATA_W, 32, width of writeback data.
- RD_W, 5, width of destination register index.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- clear  in  1  synchronous clear; same effect as reset, applied on the next edge.
- wb_en  in  1  core register-write enable in the writeback stage.
- wb_rd  in  RD_W  destination register index.
- wb_data  in  DATA_W  writeback data (WB_Data).
- out_valid  out  1  head entry available.
- out_ready  in  1  reader accepts the head entry this cycle.
- out_rd  out  RD_W  head entry register index.
- out_data  out  DATA_W  head entry data.
- count  out  log2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- overflow  out  1  sticky flag: at least one write has been dropped.
- drop_cnt  out  16  dropped-write count; saturates at 0xFFFF.
- wb_total  out  32  count of qualifying writes (accepted plus dropped); wraps modulo 2^32.

Behaviour:
- Qualifying write: wb_en=1 and wb_rd!=0. Writes to x0 are ignored entirely and do not increment wb_total.
- Push: a qualifying write is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle. Accepted writes store {wb_rd, wb_data} at the write pointer.
- Pop: occurs when out_valid=1 and out_ready=1, and advances the read pointer.
- Show-ahead FIFO: out_valid = (count!=0). out_rd and out_data are driven from the head entry. Both read 0 when out_valid=0.
- Latency: an accepted push into an empty FIFO is visible at the head (out_valid=1) on the cycle after the capturing edge. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged, ordering preserved. When empty, a pop cannot occur, so the push lands and count becomes 1.
- Full with no pop: the write is dropped, overflow is set to 1, drop_cnt increments (saturating), and FIFO contents are unchanged.
- wb_total increments on every qualifying write, accepted or dropped.
- Pointers: log2(DEPTH) bits, wrapping naturally. count is maintained as a separate register, so full and empty are unambiguous.
- out_ready while empty has no effect.
- Reset (reset=0, asynchronous):
  - Pointers, count, overflow, drop_cnt and wb_total all go to 0.
  - out_valid=0, out_rd=0, out_data=0.
  - Storage contents need not be cleared.
  - Deassertion is sampled synchronously; the first push can be captured on the first rising edge with reset=1.
- clear=1: on that edge, state goes to the reset values. clear overrides any push or pop in the same cycle, so a write presented in that cycle is discarded and not counted.
- Reset mid-operation: all queued entries are lost. out_valid falls asynchronously with reset.
- Structure: no combinational path from wb_* inputs to out_* outputs. out_valid depends only on registered state.

Test Plan:
- Single write: after reset release, wb_en=1, wb_rd=1, wb_data=0x00000002 for one cycle, out_ready=0 -> next cycle out_valid=1, out_rd=1, out_data=0x2, count=1, wb_total=1.
- x0 filter: wb_en=1, wb_rd=0, wb_data=0xDEADBEEF -> out_valid stays 0, count=0, wb_total=0.
- Fill and overflow: 18 writes, rd=1..18, data=0x100+i, out_ready=0, DEPTH=16 -> count=16, overflow=1, drop_cnt=2, wb_total=18. Then drain with out_ready=1 -> data 0x101..0x110 in order, out_valid drops after the 16th pop.
- Full with simultaneous push and pop: with count=16 and head data 0x101, push rd=5, data=0xAA with out_ready=1 -> count stays 16, no drop, 0xAA drains last.
- Wrap-around: 40 push/pop pairs with data 0..39 through DEPTH=16, ready toggling 1,0 -> data read out in exact order 0..39, final count=0, overflow=0.
- Reset and clear: reset=0 asserted mid-stream with count=7 -> out_valid=0 and count=0 before the next edge. Separately, clear=1 with a concurrent push -> count=0 and wb_total=0 after the edge.
